pipe_stage_buf: RTL and testbench

Parametrised pipeline stage buffer that replaces the plain inter-stage `buffer` between the IF/ID/EX/MEM/WB datapaths of the LC-3b pipeline. Each instance holds one stage's payload behind a valid/ready handshake with a two-entry skid, so back-pressure from a downstream stage never drops a beat and never forms a combinational ready path. It also supports synchronous flush with bubble (NOP) insertion for branch/redirect squash. An optional counter block records stall and bubble cycles.

---
 rtl/lc3b_types_pkg.sv | 22 ++
 rtl/pipe_stage_buf_perf_ctr.sv | 27 ++
 rtl/pipe_stage_buf.sv | 123 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b pipeline types: buffer state encoding and per-stage NOP payloads.
package lc3b_types;

  // Buffer occupancy state; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam int unsigned OCC_W = 2;

  // LC-3b NOP: BR with no condition bits set never branches.
  localparam logic [15:0] LC3B_NOP_INSTR = 16'h0000;

  // Bubble payloads per inter-stage buffer (control bits cleared, IR = NOP).
  localparam logic [31:0] NOP_IF_ID  = {16'h0000, LC3B_NOP_INSTR};
  localparam logic [47:0] NOP_ID_EX  = {32'h0000_0000, LC3B_NOP_INSTR};
  localparam logic [47:0] NOP_EX_MEM = {32'h0000_0000, LC3B_NOP_INSTR};
  localparam logic [47:0] NOP_MEM_WB = {32'h0000_0000, LC3B_NOP_INSTR};

endpackage

// File: rtl/pipe_stage_buf_perf_ctr.sv
// pipe_perf_ctr: saturating event counter with increment enable, cleared only by reset.
module pipe_perf_ctr #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc_en && (count_q != CNT_MAX)) begin
      count_q <= count_q + CNT_ONE;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: one inter-stage pipeline register with a two-entry skid,
// registered in_ready, and synchronous flush that leaves a bubble.
// Optional feature: define PIPE_BUF_PERF_EN to add stall/bubble counters.
module pipe_stage_buf
  import lc3b_types::*;
#(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [WIDTH-1:0]     NOP_VALUE = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
`ifdef PIPE_BUF_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] bubble_count
`endif
);

  buf_state_e       state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic in_fire_d;
  logic out_fire_d;

  // Handshakes use only registered flags, so in_ready never depends on out_ready.
  assign in_fire_d  = in_valid & in_ready_q;
  assign out_fire_d = out_valid_q & out_ready;

  // Buffer FSM: flush wins; main always holds the head beat or the NOP payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BUF_EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= BUF_EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (in_fire_d) begin
            state_q     <= BUF_ONE;
            main_q      <= in_data;
            out_valid_q <= 1'b1;
          end
        end
        BUF_ONE: begin
          if (in_fire_d && out_fire_d) begin
            main_q <= in_data;
          end else if (in_fire_d) begin
            state_q    <= BUF_FULL;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end else if (out_fire_d) begin
            state_q     <= BUF_EMPTY;
            main_q      <= NOP_VALUE;
            out_valid_q <= 1'b0;
          end
        end
        BUF_FULL: begin
          if (out_fire_d) begin
            state_q    <= BUF_ONE;
            main_q     <= skid_q;
            skid_q     <= NOP_VALUE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= BUF_EMPTY;
          main_q      <= NOP_VALUE;
          skid_q      <= NOP_VALUE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;

`ifdef PIPE_BUF_PERF_EN
  logic stall_inc_d;
  logic bubble_inc_d;

  assign stall_inc_d  = out_valid_q & ~out_ready;
  assign bubble_inc_d = ~out_valid_q;

  pipe_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_en  (stall_inc_d),
    .count   (stall_count)
  );

  pipe_perf_ctr #(.CNT_W(CNT_W)) u_bubble_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc_en  (bubble_inc_d),
    .count   (bubble_count)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: a capacity-2 FIFO queue is the reference.
module tb_pipe_stage_buf;

  localparam int          W   = 16;
  localparam logic [15:0] NOP = 16'hBEEF;
  localparam int          CW  = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          flush;
  logic [1:0]    occupancy;
`ifdef PIPE_BUF_PERF_EN
  logic [CW-1:0] stall_count;
  logic [CW-1:0] bubble_count;
`endif

  int checks = 0;
  int errors = 0;

  // Beats the buffer should currently hold, oldest first.
  logic [W-1:0] exp_q[$];
  int m_stall  = 0;
  int m_bubble = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.WIDTH(W), .NOP_VALUE(NOP), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
`ifdef PIPE_BUF_PERF_EN
    ,
    .stall_count  (stall_count),
    .bubble_count (bubble_count)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the reference queue is updated just after the edge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    logic acc;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    acc = v && !f && (exp_q.size() < 2);
    $display("drive v=%0b d=%h r=%0b f=%0b accept=%0b held=%0d", v, d, r, f, acc, exp_q.size());
    @(posedge clk);
    #1;
    if (f) exp_q.delete();
    else if (acc) exp_q.push_back(d);
  endtask

  // Monitor: checks status against the queue and pops on every output fire.
  always begin
    int held;
    logic [W-1:0] want;
    @(negedge clk);
    #1;
    if (reset_n) begin
      held = exp_q.size();
      chk("occupancy", {30'd0, occupancy}, held);
      chk("out_valid", {31'd0, out_valid}, {31'd0, held > 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, held < 2});
      if (!out_valid) chk("bubble_data", {16'd0, out_data}, {16'd0, NOP});
      if (out_valid && out_ready) begin
        if (held == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_beat actual=%h expected=none", out_data);
        end else begin
          want = exp_q.pop_front();
          $display("beat out=%h expected=%h", out_data, want);
          chk("out_data", {16'd0, out_data}, {16'd0, want});
        end
      end
`ifdef PIPE_BUF_PERF_EN
      chk("stall_count", {28'd0, stall_count}, m_stall);
      chk("bubble_count", {28'd0, bubble_count}, m_bubble);
      if (held > 0 && !out_ready && m_stall < CMAX) m_stall++;
      if (held == 0 && m_bubble < CMAX) m_bubble++;
`endif
    end else begin
      m_stall  = 0;
      m_bubble = 0;
    end
  end

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, {16'd0, NOP});
    @(negedge clk);
    reset_n = 1'b1;

    // A few idle cycles, then streaming 0x0001..0x0008 with out_ready high.
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) drive_cycle(1'b1, W'(i), 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Back-pressure: A3 is refused while full, accepted after release.
    drive_cycle(1'b1, 16'h00A1, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h00A2, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h00A3, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h00A3, 1'b1, 1'b0);
    drive_cycle(1'b1, 16'h00A3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Flush in FULL with a beat presented: nothing survives.
    drive_cycle(1'b1, 16'h1111, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h2222, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h3333, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Simultaneous in/out fire in ONE.
    drive_cycle(1'b1, 16'h0055, 1'b1, 1'b0);
    drive_cycle(1'b1, 16'h0066, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Long stall on a held beat (saturates a 4-bit stall counter).
    drive_cycle(1'b1, 16'h0077, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset while FULL, checked between clock edges.
    drive_cycle(1'b1, 16'h0A0A, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h0B0B, 1'b0, 1'b0);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_occupancy", {30'd0, occupancy}, 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    drive_cycle(1'b1, 16'h0C0C, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      drive_cycle(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    end

    // Drain and confirm nothing is left behind.
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    chk("drain_model_empty", exp_q.size(), 32'd0);
    chk("drain_occupancy", {30'd0, occupancy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
